regfile_scoreboard: RTL and testbench

- 8-entry x 16-bit register file with two combinational read ports, one synchronous write port, and a per-register pending-write scoreboard.
- Sits directly upstream of the 16-bit 2:1 operand-select mux.
- Read port B feeds the mux in0 input; the immediate feeds in1.
- Produces the stall signal that the decode stage uses to hold an instruction whose sources, or whose destination (WAW), are still awaiting writeback.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/scoreboard_bits.sv | 52 +++++
 rtl/regfile_scoreboard.sv | 75 +++++++
 tb/tb_regfile_scoreboard.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and widths used by the register file, operand mux, ALU and decoder.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 3'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/scoreboard_bits.sv
// Pending-writeback bit per register, set/clear priority and the RAW/WAW stall OR tree.
module scoreboard_bits
    import cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_en,
    input  logic [ADDR_W-1:0]       issue_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [ADDR_W-1:0]       ra_addr,
    input  logic                    ra_used,
    input  logic [ADDR_W-1:0]       rb_addr,
    input  logic                    rb_used,
    input  logic [2**ADDR_W-1:0]    byp_mask,
    output logic                    stall,
    output logic [2**ADDR_W-1:0]    pend_out
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [N_REGS-1:0] pend;
    logic [N_REGS-1:0] set_vec;
    logic [N_REGS-1:0] clr_vec;
    logic [N_REGS-1:0] pend_eff;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_en) set_vec[issue_addr] = 1'b1;
        if (wr_en)    clr_vec[wr_addr]    = 1'b1;
        set_vec[0] = 1'b0;

        pend_eff = pend & ~byp_mask;
        stall    = (ra_used  & pend_eff[ra_addr])
                 | (rb_used  & pend_eff[rb_addr])
                 | (issue_en & pend_eff[issue_addr]);
    end

    // Set is OR'd in after the clear, so a new producer supersedes a same-cycle writeback.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= (pend & ~clr_vec) | set_vec;
    end

    assign pend_out = pend;

endmodule

// File: rtl/regfile_scoreboard.sv
// 8x16 register file (R0 hardwired zero) with pending-write scoreboard and stall generation.
// Optional same-cycle write-to-read bypass when REGFILE_WR_BYPASS_EN is defined.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       ra_addr,
    input  logic                    ra_used,
    input  logic [ADDR_W-1:0]       rb_addr,
    input  logic                    rb_used,
    output logic [DATA_W-1:0]       rd_data_a,
    output logic [DATA_W-1:0]       rd_data_b,
    input  logic                    issue_en,
    input  logic [ADDR_W-1:0]       issue_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    stall,
    output logic [2**ADDR_W-1:0]    pending_mask
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [N_REGS];
    logic              wr_live;
    logic [N_REGS-1:0] byp_mask;

    assign wr_live = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

    // NOTE: the array is reset explicitly because reset must visibly zero every register;
    // this forces flops rather than a RAM macro, which is fine at 8 entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    always_comb begin
        rd_data_a = (wr_live && ra_addr == wr_addr) ? wr_data : regs[ra_addr];
        rd_data_b = (wr_live && rb_addr == wr_addr) ? wr_data : regs[rb_addr];
        byp_mask  = '0;
        if (wr_live) byp_mask[wr_addr] = 1'b1;
    end
`else
    assign rd_data_a = regs[ra_addr];
    assign rd_data_b = regs[rb_addr];
    assign byp_mask  = '0;
`endif

    scoreboard_bits #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard_bits (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .ra_addr    (ra_addr),
        .ra_used    (ra_used),
        .rb_addr    (rb_addr),
        .rb_used    (rb_used),
        .byp_mask   (byp_mask),
        .stall      (stall),
        .pend_out   (pending_mask)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations adapt to REGFILE_WR_BYPASS_EN.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ra_addr, rb_addr, issue_addr, wr_addr;
    logic        ra_used, rb_used, issue_en, wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data_a, rd_data_b;
    logic        stall;
    logic [7:0]  pending_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .ra_addr      (ra_addr),
        .ra_used      (ra_used),
        .rb_addr      (rb_addr),
        .rb_used      (rb_used),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .issue_en     (issue_en),
        .issue_addr   (issue_addr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .stall        (stall),
        .pending_mask (pending_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let combinational outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ra_addr = '0; rb_addr = '0; issue_addr = '0; wr_addr = '0;
        ra_used = 1'b0; rb_used = 1'b0; issue_en = 1'b0; wr_en = 1'b0;
        wr_data = '0;
        tick();
        rst = 1'b0;
        settle();

        // Reset state on every address
        ra_used = 1'b1; rb_used = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra_addr = 3'(i);
            rb_addr = 3'(7 - i);
            settle();
            check($sformatf("rst_rd_a[%0d]", i), 32'(rd_data_a), 32'h0);
            check($sformatf("rst_rd_b[%0d]", 7 - i), 32'(rd_data_b), 32'h0);
            check($sformatf("rst_stall[%0d]", i), 32'(stall), 32'h0);
        end
        check("rst_mask", 32'(pending_mask), 32'h00);
        ra_used = 1'b0; rb_used = 1'b0;

        // Plain write to a non-pending register
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
        tick();
        wr_en = 1'b0; ra_addr = 3'd3; rb_addr = 3'd3;
        settle();
        check("wr_r3_a", 32'(rd_data_a), 32'hA5A5);
        check("wr_r3_b", 32'(rd_data_b), 32'hA5A5);
        check("wr_r3_mask", 32'(pending_mask), 32'h00);

        // Writes to R0 are dropped
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0; ra_addr = 3'd0; rb_addr = 3'd0;
        settle();
        check("r0_a", 32'(rd_data_a), 32'h0);
        check("r0_b", 32'(rd_data_b), 32'h0);

        // Issue to R0 never sets a pending bit
        issue_en = 1'b1; issue_addr = 3'd0;
        tick();
        settle();
        check("r0_issue_stall", 32'(stall), 32'h0);
        check("r0_issue_mask", 32'(pending_mask), 32'h00);
        issue_en = 1'b0;

        // Issue R5, then RAW hazard qualified by ra_used
        issue_en = 1'b1; issue_addr = 3'd5;
        settle();
        check("iss5_pre_stall", 32'(stall), 32'h0);
        tick();
        issue_en = 1'b0; ra_addr = 3'd5; ra_used = 1'b1;
        settle();
        check("raw5_stall", 32'(stall), 32'h1);
        check("raw5_mask", 32'(pending_mask), 32'h20);
        ra_used = 1'b0;
        settle();
        check("raw5_unused", 32'(stall), 32'h0);

        // Same-cycle writeback and re-issue to R5: set wins, WAW raised
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
        issue_en = 1'b1; issue_addr = 3'd5;
        settle();
`ifdef REGFILE_WR_BYPASS_EN
        check("waw5_stall", 32'(stall), 32'h0);
`else
        check("waw5_stall", 32'(stall), 32'h1);
`endif
        tick();
        wr_en = 1'b0; issue_en = 1'b0; ra_addr = 3'd5;
        settle();
        check("r5_data", 32'(rd_data_a), 32'h1234);
        check("r5_mask", 32'(pending_mask), 32'h20);

        // Pending R2 with writeback landing in the same cycle as the read
        issue_en = 1'b1; issue_addr = 3'd2;
        tick();
        issue_en = 1'b0;
        settle();
        check("iss2_mask", 32'(pending_mask), 32'h24);
        rb_addr = 3'd2; rb_used = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00FF;
        settle();
`ifdef REGFILE_WR_BYPASS_EN
        check("same_cyc_stall", 32'(stall), 32'h0);
        check("same_cyc_rd_b", 32'(rd_data_b), 32'h00FF);
`else
        check("same_cyc_stall", 32'(stall), 32'h1);
        check("same_cyc_rd_b", 32'(rd_data_b), 32'h0);
`endif
        tick();
        wr_en = 1'b0;
        settle();
        check("after_wb_rd_b", 32'(rd_data_b), 32'h00FF);
        check("after_wb_stall", 32'(stall), 32'h0);
        check("after_wb_mask", 32'(pending_mask), 32'h20);
        rb_used = 1'b0;

        // Retire R5, load R4, then build pending mask 1/4/7
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
        tick();
        wr_addr = 3'd4; wr_data = 16'h0BEE;
        tick();
        wr_en = 1'b0;
        settle();
        check("clr5_mask", 32'(pending_mask), 32'h00);
        issue_en = 1'b1;
        issue_addr = 3'd1; tick();
        issue_addr = 3'd4; tick();
        issue_addr = 3'd7; tick();
        issue_en = 1'b0;
        settle();
        check("mask_147", 32'(pending_mask), 32'h92);
        issue_en = 1'b1; issue_addr = 3'd4;
        settle();
        check("waw4_stall", 32'(stall), 32'h1);
        issue_en = 1'b0;
        ra_addr = 3'd4;
        settle();
        check("r4_before_rst", 32'(rd_data_a), 32'h0BEE);

        // Mid-stream reset with a write in flight
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h7777;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        ra_addr = 3'd4; ra_used = 1'b1; rb_addr = 3'd3; rb_used = 1'b1;
        settle();
        check("midrst_mask", 32'(pending_mask), 32'h00);
        check("midrst_r4", 32'(rd_data_a), 32'h0);
        check("midrst_r3", 32'(rd_data_b), 32'h0);
        check("midrst_stall", 32'(stall), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
